// File: rtl/ex_share_arbiter.sv
// ex_share_arbiter: round-robin, credit-flow-controlled sharing of one combinational ex unit with a registered tagged response.
module ex_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CREDITS = 2,
    parameter int DW = 8,
    parameter int RW = 9,
    parameter int IDW = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*DW-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [DW-1:0]         ex_operand,
    input  logic [RW-1:0]         ex_result,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [RW-1:0]         rsp_data,
    input  logic [NUM_REQ-1:0]    credit_return,
    output logic                  credit_err
);
    localparam int CW = $clog2(CREDITS + 1);
    logic [NUM_REQ-1:0] grant, eligible;
    logic [IDW-1:0] gidx, ptr_q, ptr_d, rsp_id_q, rsp_id_d;
    logic [RW-1:0] rsp_data_q, rsp_data_d;
    logic rsp_valid_q, rsp_valid_d, credit_err_q, credit_err_d;
    logic [CW-1:0] credit_q [NUM_REQ];
    logic [CW-1:0] credit_d [NUM_REQ];
    int idx;
    always_comb begin
        grant = '0;
        gidx = '0;
        idx = 0;
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) eligible[i] = req_valid[i] && credit_q[i] != '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (grant == '0 && eligible[idx] && !rst) begin
                grant[idx] = 1'b1;
                gidx = IDW'(idx);
            end
        end
        ex_operand = grant != '0 ? req_data[int'(gidx)*DW +: DW] : '0;
        ptr_d = grant != '0 ? (gidx == IDW'(NUM_REQ - 1) ? '0 : gidx + 1'b1) : ptr_q;
        rsp_valid_d = grant != '0;
        rsp_id_d = grant != '0 ? gidx : rsp_id_q;
        rsp_data_d = grant != '0 ? ex_result : rsp_data_q;
        credit_err_d = credit_err_q;
        for (int i = 0; i < NUM_REQ; i++) begin
            credit_d[i] = (grant[i] && !credit_return[i]) ? credit_q[i] - 1'b1 :
                          (!grant[i] && credit_return[i] && credit_q[i] != CW'(CREDITS)) ? credit_q[i] + 1'b1 :
                          credit_q[i];
            if (!grant[i] && credit_return[i] && credit_q[i] == CW'(CREDITS)) credit_err_d = 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q <= '0;
            rsp_data_q <= '0;
            credit_err_q <= 1'b0;
            for (int i = 0; i < NUM_REQ; i++) credit_q[i] <= CW'(CREDITS);
        end else begin
            ptr_q <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
            credit_err_q <= credit_err_d;
            for (int i = 0; i < NUM_REQ; i++) credit_q[i] <= credit_d[i];
        end
    end
    assign req_ready = grant;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id = rsp_id_q;
    assign rsp_data = rsp_data_q;
    assign credit_err = credit_err_q;
endmodule

// File: tb/tb_ex_share_arbiter.sv
// tb_ex_share_arbiter: directed checks of arbitration order, credit flow control, reset behaviour and the response stage.
module tb_ex_share_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic [3:0] req_valid, req_ready, credit_return;
    logic [31:0] req_data;
    logic [7:0] ex_operand;
    logic [8:0] ex_result, rsp_data;
    logic rsp_valid, credit_err;
    logic [1:0] rsp_id;
    int errors = 0;
    int checks = 0;
    int cnt [4];

    ex_share_arbiter dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .ex_operand(ex_operand), .ex_result(ex_result), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .credit_return(credit_return), .credit_err(credit_err)
    );

    function automatic logic [8:0] ex_f(input logic [7:0] x);
        return {x, 1'b0} ^ 9'h15A;
    endfunction

    assign ex_result = ex_f(ex_operand);
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        credit_return = '0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 4'hF;
        credit_return = '0;
        req_data = {8'h44, 8'h33, 8'h22, 8'h10};
        #1;
        chk("ready_gated_in_rst", req_ready, 4'h0);
        chk("operand_in_rst", ex_operand, 8'h00);
        tick();
        tick();
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id", rsp_id, 2'd0);
        chk("rst_rsp_data", rsp_data, 9'h000);
        chk("rst_credit_err", credit_err, 1'b0);
        req_valid = '0;
        rst = 1'b0;
        tick();
        // single requester drains its two credits, then one return buys one more grant
        req_valid = 4'b0001;
        #1;
        chk("single_ready0", req_ready, 4'b0001);
        chk("single_operand", ex_operand, 8'h10);
        tick();
        chk("single_rsp1_valid", rsp_valid, 1'b1);
        chk("single_rsp1_id", rsp_id, 2'd0);
        chk("single_rsp1_data", rsp_data, ex_f(8'h10));
        chk("single_ready1", req_ready, 4'b0001);
        tick();
        chk("single_rsp2_valid", rsp_valid, 1'b1);
        chk("single_rsp2_data", rsp_data, ex_f(8'h10));
        chk("single_ready2", req_ready, 4'b0000);
        tick();
        chk("single_rsp3_valid", rsp_valid, 1'b0);
        chk("single_ready3", req_ready, 4'b0000);
        credit_return = 4'b0001;
        #1;
        chk("single_ready_during_return", req_ready, 4'b0000);
        tick();
        credit_return = '0;
        #1;
        chk("single_ready_after_return", req_ready, 4'b0001);
        tick();
        chk("single_rsp4_valid", rsp_valid, 1'b1);
        chk("single_ready_after_one", req_ready, 4'b0000);
        tick();
        chk("single_no_more", req_ready, 4'b0000);
        do_reset();
        // round robin with every accept immediately credited back
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'hF;
        cnt = '{0, 0, 0, 0};
        for (int k = 0; k < 16; k++) begin
            #1;
            chk($sformatf("rr_ready_%0d", k), req_ready, 32'd1 << (k % 4));
            chk($sformatf("rr_operand_%0d", k), ex_operand, 8'h11 * ((k % 4) + 1));
            for (int i = 0; i < 4; i++) if (req_ready[i]) cnt[i]++;
            credit_return = req_ready;
            tick();
            credit_return = '0;
            chk($sformatf("rr_rsp_valid_%0d", k), rsp_valid, 1'b1);
            chk($sformatf("rr_rsp_id_%0d", k), rsp_id, k % 4);
            chk($sformatf("rr_rsp_data_%0d", k), rsp_data, ex_f(8'(8'h11 * ((k % 4) + 1))));
        end
        for (int i = 0; i < 4; i++) chk($sformatf("rr_count_%0d", i), cnt[i], 4);
        do_reset();
        // exhaust req1, leave pointer at 1
        req_valid = 4'b0010;
        #1;
        chk("skip_setup_a", req_ready, 4'b0010);
        tick();
        chk("skip_setup_b", req_ready, 4'b0010);
        tick();
        req_valid = 4'b0001;
        #1;
        chk("skip_setup_c", req_ready, 4'b0001);
        tick();
        req_valid = 4'b0111;
        #1;
        chk("skip_grant2", req_ready, 4'b0100);
        tick();
        chk("skip_rsp_id2", rsp_id, 2'd2);
        chk("skip_grant0", req_ready, 4'b0001);
        tick();
        chk("skip_rsp_id0", rsp_id, 2'd0);
        chk("skip_grant2b", req_ready, 4'b0100);
        tick();
        chk("skip_none", req_ready, 4'b0000);
        credit_return = 4'b0010;
        #1;
        chk("skip_none_during_return", req_ready, 4'b0000);
        tick();
        credit_return = '0;
        #1;
        chk("skip_grant1_after_return", req_ready, 4'b0010);
        do_reset();
        // simultaneous accept and return on req3
        req_valid = 4'b1000;
        #1;
        chk("sim_first", req_ready, 4'b1000);
        tick();
        chk("sim_second", req_ready, 4'b1000);
        credit_return = 4'b1000;
        tick();
        credit_return = '0;
        #1;
        chk("sim_regrant", req_ready, 4'b1000);
        tick();
        chk("sim_exhausted", req_ready, 4'b0000);
        do_reset();
        // overflow return at full credit
        credit_return = 4'b0100;
        #1;
        chk("ovf_err_before", credit_err, 1'b0);
        tick();
        credit_return = '0;
        chk("ovf_err_set", credit_err, 1'b1);
        req_valid = 4'b0100;
        #1;
        chk("ovf_grant_a", req_ready, 4'b0100);
        tick();
        chk("ovf_grant_b", req_ready, 4'b0100);
        tick();
        chk("ovf_grant_none", req_ready, 4'b0000);
        chk("ovf_err_sticky", credit_err, 1'b1);
        do_reset();
        chk("ovf_err_cleared", credit_err, 1'b0);
        // reset during back-to-back grants
        req_valid = 4'hF;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_ready_gated", req_ready, 4'b0000);
        chk("mid_operand_zero", ex_operand, 8'h00);
        chk("mid_rsp_presented", rsp_valid, 1'b1);
        chk("mid_rsp_id", rsp_id, 2'd1);
        tick();
        chk("mid_rsp_cleared", rsp_valid, 1'b0);
        chk("mid_rsp_data_cleared", rsp_data, 9'h000);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk($sformatf("burst_ready_%0d", k), req_ready, 32'd1 << (k % 4));
            tick();
        end
        chk("burst_exhausted", req_ready, 4'b0000);
        req_valid = '0;
        tick();
        chk("idle_operand", ex_operand, 8'h00);
        tick();
        chk("idle_rsp_valid", rsp_valid, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ex_share_arbiter.md
Name: ex_share_arbiter

Overview:
- Shares one combinational `ex` unit (8-bit mac_result in, 9-bit ex_result out) between NUM_REQ attention-head requesters.
- Round-robin arbitration with per-requester credit-based output flow control.
- A single registered response stage returns the exp result, tagged with the requester id.
- Sits between the per-head MAC stages and the softmax accumulate/normalize consumers. The `ex` instance is external and is driven through the ex_operand / ex_result pair.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CREDITS, 2, consumer buffer slots per requester (1..7); also the reset credit value.
- DW, 8, operand width (matches mac_result).
- RW, 9, result width (matches ex_result).
- IDW, $clog2(NUM_REQ), response id width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_data  input  NUM_REQ*DW  operands; requester i uses bits [i*DW +: DW].
- req_ready  output  NUM_REQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both 1.
- ex_operand  output  DW  operand to the external ex unit (its mac_result).
- ex_result  input  RW  combinational result from the external ex unit.
- rsp_valid  output  1  response valid. There is no ready: the consumer is guaranteed space by credits.
- rsp_id  output  IDW  requester index of the response.
- rsp_data  output  RW  registered ex_result.
- credit_return  input  NUM_REQ  one-cycle pulse per freed consumer slot.
- credit_err  output  1  sticky flag: a credit was returned while the counter was already at CREDITS.

Behaviour:
- Reset (rst=1 at a clock edge):
  - rsp_valid=0, rsp_id=0, rsp_data=0, credit_err=0.
  - All credit counters = CREDITS; round-robin pointer = 0.
  - req_ready is forced to all zeros while rst=1 (combinational gating).
- Eligibility: eligible[i] = req_valid[i] & (credit[i] != 0).
- Grant (combinational, same cycle):
  - Grant the first eligible index searching from the pointer upward, wrapping modulo NUM_REQ.
  - At most one grant per cycle. req_ready = grant one-hot. If nothing is eligible, req_ready = 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
- Operand mux: ex_operand = req_data of the granted requester; ex_operand = 0 when there is no grant.
- Response stage, on every edge:
  - rsp_valid <= (grant != 0).
  - On a grant: rsp_id <= granted index, rsp_data <= ex_result.
  - With no grant, rsp_id and rsp_data hold their previous values.
  - Latency is 1 cycle from accept to rsp_valid. Throughput is one response per cycle, back-to-back.
- Pointer: on a grant to index g, pointer <= (g+1) mod NUM_REQ. With no grant the pointer holds.
- Credits, per requester i:
  - Decrement on accept (not on rsp issue), so in-flight responses are counted.
  - Increment on credit_return[i].
  - Accept and return in the same cycle: counter unchanged.
  - Return with no accept while the counter equals CREDITS: counter stays at CREDITS (saturate) and credit_err <= 1.
  - The counter can never go below 0, because a requester with zero credits is never granted.
- Credit exhaustion: a requester at 0 credits is skipped by the arbiter. Other requesters proceed unblocked. There is no head-of-line blocking.
- Reset mid-operation:
  - A response launched in the cycle before rst is still presented on rsp_valid. The reset edge then clears rsp_valid.
  - In-flight credits are restored to CREDITS. The consumer is reset concurrently.
- credit_err clears only on rst.

Test Plan:
- Single requester: CREDITS=2; req0 presents 0x10 continuously and no credits return.
  - req_ready[0] is high for 2 cycles and then 0.
  - Two rsp_valid pulses, each rsp_id=0 and rsp_data = ex(0x10) from the bench's ex instance.
  - Then one credit_return[0] pulse → exactly one further grant.
- Round-robin fairness: all 4 requesters valid with unlimited credit returns.
  - Grant order is 0,1,2,3,0,1,...
  - rsp_id follows the same sequence one cycle later.
  - Over 16 cycles each requester gets exactly 4 grants.
- Skip on exhaustion: req1 at 0 credits; req0, req1, req2 valid; pointer=1.
  - Grant goes to 2, then 0. req1 gets no grant until credit_return[1], and is granted the cycle after that return.
- Simultaneous accept and return: req3 has 1 credit and is accepted while credit_return[3]=1 in the same cycle.
  - Credit stays 1 and req3 is granted again next cycle.
- Credit overflow: at reset state, pulse credit_return[2].
  - credit_err=1 on the next cycle and remains 1 until rst. Credit[2] stays CREDITS.
- Reset mid-stream: assert rst during back-to-back grants.
  - req_ready=0 the same cycle; rsp_valid=0 after the edge.
  - Credits read back as CREDITS via a full-credit burst after reset; pointer restarts at 0.
  - Idle with no valid: ex_operand=0 and rsp_valid=0.
